// File: rtl/sm_filter_channel.sv
// One input channel: synchroniser chain, stability counter, filtered level and edge flags.
module sm_filter_channel #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic [CNT_W-1:0] stable_cycles,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             upd
);

  localparam logic [CNT_W-1:0] MIN_THR = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       thr;
  logic [CNT_W:0]         cnt_inc;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign thr     = (stable_cycles == '0) ? MIN_THR : stable_cycles;
  // One extra bit keeps the compare exact even when cnt sits at its maximum.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign upd     = (s != q) && (cnt_inc >= {1'b0, thr});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      q      <= RESET_BIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (upd) begin
        q    <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else if (s == q) begin
        cnt  <= '0;
      end else begin
        cnt  <= cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sm_input_filter.sv
// Multi-channel input conditioner: synchronise, deglitch, and report level changes.
module sm_input_filter #(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       CNT_W       = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] stableCycles,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] upd;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    sm_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_BIT   (RESET_VAL[g])
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .d             (d[g]),
      .stable_cycles (stableCycles),
      .q             (q[g]),
      .rise          (rise[g]),
      .fall          (fall[g]),
      .upd           (upd[g])
    );
  end

  // Registered from the channels' update terms so it lands on the same edge as rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |upd;
  end

endmodule

// File: doc/sm_input_filter.md
Name: sm_input_filter

Overview:
- Parametrised successor to the two-flop input debouncer: a multi-channel input conditioner.
- Synchronises WIDTH asynchronous inputs (switches, buttons, divider select) through a configurable-depth flop chain.
- Rejects glitches shorter than a runtime-programmable stability window.
- Emits the filtered level plus one-cycle rise/fall pulses per channel and an any-change strobe.
- Sits at the board-input boundary of the top level and feeds the clock divider control, the CPU and the debug-screen logic.

Parameters:
- WIDTH, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flop depth per channel; legal range 2..4.
- CNT_W, 16, width of the stability counter and of the stableCycles port.
- RESET_VAL, 0 (WIDTH bits), value of q after reset; rise/fall are never pulsed by reset.

Ports:
- clk  in  1  system clock; single clock domain for all state.
- rst_n  in  1  asynchronous active-low reset.
- d  in  WIDTH  raw asynchronous inputs.
- stableCycles  in  CNT_W  required consecutive cycles of disagreement before q follows; quasi-static, sampled every cycle.
- q  out  WIDTH  filtered, synchronised level.
- rise  out  WIDTH  one-cycle pulse when q[i] goes 0->1.
- fall  out  WIDTH  one-cycle pulse when q[i] goes 1->0.
- changed  out  1  registered OR of rise|fall, aligned with them.

Behaviour:
- Reset (rst_n low, asynchronous): sync chain <= RESET_VAL, q <= RESET_VAL, counters <= 0, rise/fall/changed <= 0.
- Sync chain: s[i] is the output of stage SYNC_STAGES of a shift chain clocked by clk. It is the only path from d into the logic; no combinational use of d.
- Effective threshold: thr = (stableCycles == 0) ? 1 : stableCycles.
- Per channel, each rising clk edge:
  - If s == q: cnt <= 0, no pulse.
  - If s != q and cnt+1 >= thr: q <= s, cnt <= 0, rise or fall <= 1 according to the new value.
  - Otherwise: cnt <= cnt+1.
  - rise/fall are deasserted on every edge that does not update q.
- Latency: a clean step on d set up before edge E0 appears on q at edge E0+SYNC_STAGES+thr-1. With SYNC_STAGES=2 and thr=4, q changes on the 6th edge, counting E0 as the 1st.
- Glitch rejection: any return of s to q before the window completes resets cnt to 0. Pulses of s shorter than thr cycles never reach q.
- Counter width: cnt is CNT_W bits and is compared with >=. It never wraps, because it is cleared no later than reaching thr-1 (≤ 2^CNT_W - 2).
- Threshold changed mid-count: the new value applies on the next edge. If lowered to ≤ cnt+1, q updates on that edge; if raised, counting continues from the current cnt.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses; changed is asserted once.
- changed is registered in the same cycle as rise/fall (same edge), not derived combinationally from them.
- Reset mid-count: all counts are discarded and q returns to RESET_VAL with no pulse. After release, a d differing from RESET_VAL needs a full SYNC_STAGES+thr window.

Decomposition:
- No shared package; the only constant (minimum threshold 1) is local.
- One sub-module, sm_filter_channel: one bit of sync chain, counter, q and edge flags, parametrised by SYNC_STAGES, CNT_W and reset bit.
- The top instantiates WIDTH copies via generate and ORs the pulses into the changed register.

Test Plan:
- Reset with RESET_VAL=4'b0101, d=4'b0101 held → q=4'b0101, rise=fall=changed=0 for 20 cycles after release.
- stableCycles=4, SYNC_STAGES=2: step d[0] 0->1 before edge E0 → q[0]=1, rise[0]=1 and changed=1 exactly at E0+5, all pulses low at E0+6.
- stableCycles=4: d[1] high for 3 cycles then low → q[1], rise[1] and changed never assert; the internal count returns to 0.
- stableCycles=0: step d[2] → q[2] changes at E0+2, identical to stableCycles=1.
- Threshold change mid-count: stableCycles=100, step d[3]; after 10 cycles of disagreement write stableCycles=5 → q[3] updates on the next edge with fall[3]/rise[3] pulsed.
- Simultaneous steps on d[0] (1->0) and d[1] (0->1), then rst_n asserted mid-window on a second step → first: fall[0] and rise[1] on the same edge, one changed pulse; second: q=RESET_VAL immediately, no pulses.
